reg_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-bit register-load bus among four requesters and sequences the load strobes of the 4-register bank. Each requester asks to write one value into one register. The arbiter grants one requester at a time and captures its data and destination. It drives the bus for a settle period, pulses the destination register's load enable for one cycle, then acknowledges the requester. It sits between the control/microcode sources and the register bank.

---
 rtl/reg_bus_arbiter_pkg.sv | 20 ++
 rtl/reg_bus_arbiter_rr_pick4.sv | 26 ++
 rtl/reg_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the register-load bus arbiter.
// Also provides a small one-hot helper used by the arbiter and its bench.
package reg_bus_arbiter_pkg;

    localparam int NREQ     = 4;
    localparam int NREG     = 4;
    localparam int DST_W    = 2;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOAD
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_pick4.sv
// Combinational round-robin selector over four requesters.
// Search starts at (last+1) mod 4; nearest active requester wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from farthest to nearest so the nearest requester overwrites
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin owner of the register-load bus and bank load strobes.
// Grants one writer, drives its data for SETTLE cycles, then loads and acks.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DST_W-1:0]  dst,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_oe,
    output logic [NREG-1:0]        reg_load,
    output logic                   busy
);

    localparam logic [SETTLE_W-1:0] CNT_INIT = SETTLE_W'(SETTLE - 1);

    state_t state_q, state_d;

    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          win_q, win_d;
    logic [DST_W-1:0]    dst_q, dst_d;

    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              bus_oe_q, bus_oe_d;
    logic [NREG-1:0]   reg_load_q, reg_load_d;
    logic              busy_q, busy_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       settle_done;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign settle_done = (cnt_q == '0);

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DRIVE holds until the settle counter expires
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = DRIVE;
            DRIVE:   if (settle_done) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture winner/destination at grant, count settle, advance pointer
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        win_d  = win_q;
        dst_d  = dst_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cnt_d = CNT_INIT;
                    win_d = pick_idx;
                    dst_d = dst[int'(pick_idx)*DST_W +: DST_W];
                end
            end
            DRIVE: begin
                if (!settle_done) cnt_d = cnt_q - SETTLE_W'(1);
            end
            LOAD: begin
                last_d = win_q;
            end
            default: ;
        endcase
    end

    // Datapath registers; last resets to 3 so requester 0 leads
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= 2'd3;
            win_q  <= 2'd0;
            dst_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            win_q  <= win_d;
            dst_q  <= dst_d;
        end
    end

    // Output decode: next values for the registered outputs
    always_comb begin
        grant_d    = '0;
        ack_d      = '0;
        bus_data_d = '0;
        bus_oe_d   = 1'b0;
        reg_load_d = '0;
        busy_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = onehot4(pick_idx);
                    bus_data_d = wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    bus_oe_d   = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            DRIVE: begin
                grant_d    = grant_q;
                bus_data_d = bus_data_q;
                bus_oe_d   = 1'b1;
                busy_d     = 1'b1;
                if (settle_done) begin
                    reg_load_d = onehot4(dst_q);
                    ack_d      = grant_q;
                end
            end
            LOAD:    ;
            default: ;
        endcase
    end

    // Output flops; no input reaches an output without a register
    always_ff @(posedge clock) begin
        if (rst) begin
            grant_q    <= '0;
            ack_q      <= '0;
            bus_data_q <= '0;
            bus_oe_q   <= 1'b0;
            reg_load_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            bus_data_q <= bus_data_d;
            bus_oe_q   <= bus_oe_d;
            reg_load_q <= reg_load_d;
            busy_q     <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign bus_data = bus_data_q;
    assign bus_oe   = bus_oe_q;
    assign reg_load = reg_load_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with SETTLE=1 and SETTLE=3 instances.
// A falling-edge register bank model shows what each write really loads.
module tb_reg_bus_arbiter;
    import reg_bus_arbiter_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst1, rst3;
    logic [3:0]  req1, req3;
    logic [7:0]  dst1, dst3;
    logic [15:0] wd1, wd3;

    logic [3:0] g1, a1, bd1, rl1;
    logic       oe1, bz1;
    logic [3:0] g3, a3, bd3, rl3;
    logic       oe3, bz3;

    logic [3:0] bank1 [4] = '{default: 4'h0};
    logic [3:0] bank3 [4] = '{default: 4'h0};

    int n_err = 0;
    int n_chk = 0;

    reg_bus_arbiter #(.DATA_W(4), .SETTLE(1)) u1 (
        .clock    (clock),
        .rst      (rst1),
        .req      (req1),
        .dst      (dst1),
        .wdata    (wd1),
        .grant    (g1),
        .ack      (a1),
        .bus_data (bd1),
        .bus_oe   (oe1),
        .reg_load (rl1),
        .busy     (bz1)
    );

    reg_bus_arbiter #(.DATA_W(4), .SETTLE(3)) u3 (
        .clock    (clock),
        .rst      (rst3),
        .req      (req3),
        .dst      (dst3),
        .wdata    (wd3),
        .grant    (g3),
        .ack      (a3),
        .bus_data (bd3),
        .bus_oe   (oe3),
        .reg_load (rl3),
        .busy     (bz3)
    );

    // Register bank captures on the falling edge
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (rl1[i]) bank1[i] <= bd1;
            if (rl3[i]) bank3[i] <= bd3;
        end
    end

    task automatic check(input string tag,
                         input logic [3:0] got,
                         input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle1(input string tag);
        check({tag, "_g"}, g1, 4'h0);
        check({tag, "_a"}, a1, 4'h0);
        check({tag, "_rl"}, rl1, 4'h0);
        check({tag, "_bd"}, bd1, 4'h0);
        check({tag, "_oe"}, {3'b0, oe1}, 4'h0);
        check({tag, "_bz"}, {3'b0, bz1}, 4'h0);
    endtask

    task automatic idle3(input string tag);
        check({tag, "_g"}, g3, 4'h0);
        check({tag, "_a"}, a3, 4'h0);
        check({tag, "_rl"}, rl3, 4'h0);
        check({tag, "_bd"}, bd3, 4'h0);
        check({tag, "_oe"}, {3'b0, oe3}, 4'h0);
        check({tag, "_bz"}, {3'b0, bz3}, 4'h0);
    endtask

    initial begin
        logic [3:0] exp;
        rst1 = 1'b1;
        rst3 = 1'b1;
        req1 = 4'b1111;
        req3 = 4'b0000;
        dst1 = 8'h00;
        dst3 = 8'h00;
        wd1  = 16'h0000;
        wd3  = 16'h0000;

        // Reset held two cycles with every request up
        tick();
        idle1("rst1");
        tick();
        idle1("rst2");
        rst1 = 1'b0;
        tick();
        check("first_grant", g1, 4'b0001);
        check("first_busy", {3'b0, bz1}, 4'h1);
        req1 = 4'b0000;
        tick();
        check("first_ack", a1, 4'b0001);
        tick();
        idle1("first_end");

        // Single write: requester 0 writes A into register 2
        dst1 = 8'b0000_0010;
        wd1  = 16'h000A;
        req1 = 4'b0001;
        tick();
        check("sw_grant", g1, 4'b0001);
        check("sw_bd", bd1, 4'hA);
        check("sw_oe", {3'b0, oe1}, 4'h1);
        check("sw_rl0", rl1, 4'h0);
        check("sw_a0", a1, 4'h0);
        tick();
        check("sw_grant2", g1, 4'b0001);
        check("sw_rl", rl1, 4'b0100);
        check("sw_bd2", bd1, 4'hA);
        check("sw_ack", a1, 4'b0001);
        req1 = 4'b0000;
        tick();
        idle1("sw_end");
        check("sw_reg2", bank1[2], 4'hA);

        // Round robin from reset: 0,1,2,3,0 every 3 cycles
        rst1 = 1'b1;
        tick();
        check("rr_rst", g1, 4'h0);
        rst1 = 1'b0;
        req1 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp = onehot4(2'(i % 4));
            tick();
            check("rr_grant", g1, exp);
            check("rr_noack", a1, 4'h0);
            tick();
            check("rr_ack", a1, exp);
            if (i == 4) req1 = 4'b0000;
            tick();
            check("rr_gap", g1, 4'h0);
        end

        // Serve requester 1, dropping req after grant
        req1 = 4'b0010;
        tick();
        check("r1_grant", g1, 4'b0010);
        req1 = 4'b0000;
        tick();
        check("r1_ack", a1, 4'b0010);
        tick();
        idle1("r1_end");

        // Contention 0 and 2: 2 wins, late wdata change is ignored
        dst1 = 8'b0011_0000;
        wd1  = 16'h0507;
        req1 = 4'b0101;
        tick();
        check("ct_grant2", g1, 4'b0100);
        check("ct_bd2", bd1, 4'h5);
        wd1 = 16'h0F07;
        tick();
        check("ct_rl2", rl1, 4'b1000);
        check("ct_bd2b", bd1, 4'h5);
        check("ct_ack2", a1, 4'b0100);
        req1 = 4'b0001;
        tick();
        check("ct_gap", g1, 4'h0);
        tick();
        check("ct_grant0", g1, 4'b0001);
        check("ct_reg3", bank1[3], 4'h5);
        tick();
        check("ct_ack0", a1, 4'b0001);
        check("ct_bd0", bd1, 4'h7);
        check("ct_rl0", rl1, 4'b0001);
        req1 = 4'b0000;
        tick();
        idle1("ct_end");
        check("ct_reg0", bank1[0], 4'h7);

        // SETTLE=3: load rises 3 cycles after grant, bus steady
        rst3 = 1'b0;
        tick();
        idle3("s3_idle");
        dst3 = 8'b0000_0001;
        wd3  = 16'h0009;
        req3 = 4'b0001;
        tick();
        check("s3_grant", g3, 4'b0001);
        check("s3_oe0", {3'b0, oe3}, 4'h1);
        check("s3_bd0", bd3, 4'h9);
        check("s3_rl0", rl3, 4'h0);
        req3 = 4'b0000;
        wd3  = 16'h0006;
        for (int k = 1; k <= 2; k++) begin
            tick();
            check("s3_rl_wait", rl3, 4'h0);
            check("s3_oe_wait", {3'b0, oe3}, 4'h1);
            check("s3_bd_wait", bd3, 4'h9);
        end
        tick();
        check("s3_rl", rl3, 4'b0010);
        check("s3_ack", a3, 4'b0001);
        check("s3_oe3", {3'b0, oe3}, 4'h1);
        check("s3_bd3", bd3, 4'h9);
        tick();
        idle3("s3_end");
        check("s3_reg1", bank3[1], 4'h9);

        // Reset in 2nd DRIVE cycle aborts the write to register 2
        dst3 = 8'b0010_0000;
        wd3  = 16'h0C00;
        req3 = 4'b0100;
        tick();
        check("rd_grant", g3, 4'b0100);
        req3 = 4'b0000;
        tick();
        check("rd_drive", g3, 4'b0100);
        check("rd_rl0", rl3, 4'h0);
        rst3 = 1'b1;
        tick();
        idle3("rd_rst");
        rst3 = 1'b0;
        req3 = 4'b1010;
        tick();
        check("rd_grant1", g3, 4'b0010);
        check("rd_nork", rl3, 4'h0);
        check("rd_reg2", bank3[2], 4'h0);
        req3 = 4'b0000;
        tick();
        tick();
        tick();
        check("rd_ack1", a3, 4'b0010);
        tick();
        idle3("rd_end");
        check("rd_reg2b", bank3[2], 4'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
